sdram_cmd_arbiter: RTL and testbench

- Multi-port front end for the SDRAM controller. Merges NUM_PORTS client command streams into one controller command stream using round-robin arbitration.
- Write bursts are locked to a single port until the last beat. Each read issue records the requesting port in an in-order tag FIFO, so returning read data is routed back to the correct client.
- Extends the single-port read/write/addr/wdata/auto-precharge command with a byte mask, a burst length and a port id.

---
 rtl/sdram_cmd_arbiter_if.sv | 53 +++++
 rtl/sdram_cmd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_arbiter_if.sv
// Signal bundle between the SDRAM command arbiter, its client ports and the controller.
// The slave modport is the arbiter's view; master is the environment's view.
interface sdram_cmd_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_WIDTH = 3,
  parameter int PW          = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]                  req_valid;
  logic [NUM_PORTS-1:0]                  req_ready;
  logic [NUM_PORTS-1:0]                  req_rw;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0]     req_wmask;
  logic [NUM_PORTS*BURST_WIDTH-1:0]      req_burst;
  logic [NUM_PORTS-1:0]                  req_ap;

  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic                                  cmd_rw;
  logic [ADDR_WIDTH-1:0]                 cmd_addr;
  logic [DATA_WIDTH-1:0]                 cmd_wdata;
  logic [DATA_WIDTH/8-1:0]               cmd_wmask;
  logic [BURST_WIDTH-1:0]                cmd_burst;
  logic                                  cmd_ap;
  logic [PW-1:0]                         cmd_port;
  logic                                  cmd_first;

  logic                                  rd_valid;
  logic [DATA_WIDTH-1:0]                 rd_data;
  logic                                  rd_last;
  logic [NUM_PORTS-1:0]                  rsp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0]       rsp_data;
  logic [NUM_PORTS-1:0]                  rsp_last;

  logic                                  tags_full;
  logic                                  err;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_wmask, req_burst, req_ap,
    input  cmd_ready, rd_valid, rd_data, rd_last,
    output req_ready, cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_wmask, cmd_burst,
    output cmd_ap, cmd_port, cmd_first, rsp_valid, rsp_data, rsp_last, tags_full, err
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_wmask, req_burst, req_ap,
    output cmd_ready, rd_valid, rd_data, rd_last,
    input  req_ready, cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_wmask, cmd_burst,
    input  cmd_ap, cmd_port, cmd_first, rsp_valid, rsp_data, rsp_last, tags_full, err
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Round-robin merge of client command streams into one SDRAM controller stream, with
// write-burst locking and an in-order read tag FIFO that routes returning data to its client.
module sdram_cmd_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_WIDTH = 3,
  parameter int TAG_DEPTH   = 8,
  parameter int PW          = $clog2(NUM_PORTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_cmd_arbiter_if.slave bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = $clog2(TAG_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [1:0]             state_r;
  logic [PW-1:0]          grant_r;
  logic [PW-1:0]          last_grant_r;
  logic [BURST_WIDTH-1:0] beat_cnt_r;
  logic                   first_beat_r;

  logic [PW-1:0]          tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       tag_cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   tags_full_r;
  logic                   err_r;

  logic [NUM_PORTS-1:0]   elig_s;
  logic                   win_found_s;
  logic [PW-1:0]          win_s;
  logic [PW-1:0]          idx_s;
  logic                   hit_s;
  logic                   active_s;
  logic                   hs_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   tag_empty_s;
  logic [PW-1:0]          head_s;

  logic [NUM_PORTS-1:0]   req_ready_s;
  logic                   cmd_valid_s;
  logic                   cmd_rw_s;
  logic                   cmd_first_s;
  logic [NUM_PORTS-1:0]   rsp_valid_s;
  logic [NUM_PORTS-1:0]   rsp_last_s;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PW-1:0] idx);
    logic [NUM_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Port eligibility: reads are held off while the tag FIFO is full
  always_comb begin
    elig_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig_s[p] = bus.req_valid[p] && (!bus.req_rw[p] || !tags_full_r);
    end
  end

  // Round-robin search starting just after the last granted port
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    idx_s       = '0;
    hit_s       = 1'b0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx_s       = PW'((int'(last_grant_r) + off) % NUM_PORTS);
      hit_s       = !win_found_s && elig_s[idx_s];
      win_s       = hit_s ? idx_s : win_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Pass-through of the granted port towards the controller
  always_comb begin
    active_s    = (state_r == ST_GRANT) || (state_r == ST_BURST);
    cmd_valid_s = active_s && bus.req_valid[grant_r];
    req_ready_s = (active_s && bus.cmd_ready) ? port_onehot(grant_r) : '0;
    hs_s        = cmd_valid_s && bus.cmd_ready;
    // burst beats are always forwarded as writes, whatever the client drives
    cmd_rw_s    = (state_r == ST_BURST) ? 1'b0 : bus.req_rw[grant_r];
    case (state_r)
      ST_GRANT: cmd_first_s = 1'b1;
      ST_BURST: cmd_first_s = first_beat_r;
      default:  cmd_first_s = 1'b0;
    endcase
  end

  // Tag FIFO control and read-return routing
  always_comb begin
    tag_empty_s = (tag_cnt_r == CNT_W'(0));
    head_s      = tag_mem_r[rd_ptr_r];
    push_s      = hs_s && (state_r == ST_GRANT) && bus.req_rw[grant_r];
    pop_s       = bus.rd_valid && bus.rd_last && !tag_empty_s;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = tag_cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = tag_cnt_r - CNT_W'(1);
      default: cnt_nxt_s = tag_cnt_r;
    endcase
    if (bus.rd_valid && !tag_empty_s) begin
      rsp_valid_s = port_onehot(head_s);
      rsp_last_s  = bus.rd_last ? port_onehot(head_s) : '0;
    end else begin
      rsp_valid_s = '0;
      rsp_last_s  = '0;
    end
  end

  // Arbitration FSM with burst beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= PW'(NUM_PORTS - 1);
      beat_cnt_r   <= '0;
      first_beat_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            grant_r      <= win_s;
            last_grant_r <= win_s;
            beat_cnt_r   <= bus.req_burst[int'(win_s) * BURST_WIDTH +: BURST_WIDTH];
            first_beat_r <= 1'b1;
            if (bus.req_rw[win_s] ||
                (bus.req_burst[int'(win_s) * BURST_WIDTH +: BURST_WIDTH] == BURST_WIDTH'(0))) begin
              state_r <= ST_GRANT;
            end else begin
              state_r <= ST_BURST;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (hs_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        ST_BURST: begin
          if (hs_s) begin
            first_beat_r <= 1'b0;
            if (beat_cnt_r == BURST_WIDTH'(0)) begin
              state_r <= ST_IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r - BURST_WIDTH'(1);
            end
          end else begin
            state_r <= ST_BURST;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Tag FIFO storage; contents need no reset since occupancy governs validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= grant_r;
    end
  end

  // Tag FIFO pointers, occupancy and full flag (from next count so a read cannot slip in)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      tag_cnt_r   <= '0;
      tags_full_r <= 1'b0;
    end else begin
      wr_ptr_r    <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r    <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      tag_cnt_r   <= cnt_nxt_s;
      tags_full_r <= (cnt_nxt_s == CNT_W'(TAG_DEPTH));
    end
  end

  // Sticky protocol error: read opcode inside a write burst, or orphan read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_BURST && hs_s && bus.req_rw[grant_r]) ||
                 (bus.rd_valid && tag_empty_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.cmd_valid = cmd_valid_s;
  assign bus.cmd_rw    = cmd_rw_s;
  assign bus.cmd_addr  = bus.req_addr[int'(grant_r) * ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.cmd_wdata = bus.req_wdata[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
  assign bus.cmd_wmask = bus.req_wmask[int'(grant_r) * MASK_WIDTH +: MASK_WIDTH];
  assign bus.cmd_burst = bus.req_burst[int'(grant_r) * BURST_WIDTH +: BURST_WIDTH];
  assign bus.cmd_ap    = bus.req_ap[grant_r];
  assign bus.cmd_port  = grant_r;
  assign bus.cmd_first = cmd_first_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_last  = rsp_last_s;
  assign bus.rsp_data  = {NUM_PORTS{bus.rd_data}};
  assign bus.tags_full = tags_full_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: per-port expected beats are queued when clients are
// loaded and compared at each controller handshake; read returns are checked against a tag model.
module tb_sdram_cmd_arbiter;
  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 3;
  localparam int MW = DW / 8;
  localparam int TD = 8;

  typedef struct packed {
    logic          rw;
    logic          exp_rw;
    logic          first;
    logic          ap;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [BW-1:0] burst;
  } beat_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks_cnt;
  int   errors_cnt;
  int   t0;

  beat_t          port_q [NP][$];
  beat_t          exp_q  [NP][$];
  int             tag_model[$];
  bit             acc [NP];
  int             hs_port[$];
  int             hs_cyc[$];
  int             hs_first[$];
  logic [NP-1:0]  rsp_log[$];

  sdram_cmd_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  sdram_cmd_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .TAG_DEPTH(TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int log_port(input int i);
    return (i < hs_port.size()) ? hs_port[i] : -1;
  endfunction
  function automatic int log_cyc(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1000;
  endfunction
  function automatic int log_first(input int i);
    return (i < hs_first.size()) ? hs_first[i] : -1;
  endfunction
  function automatic int rsp_at(input int i);
    return (i < rsp_log.size()) ? int'(rsp_log[i]) : -1;
  endfunction
  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += port_q[p].size();
    return n;
  endfunction
  function automatic int exp_left();
    int n = 0;
    for (int p = 0; p < NP; p++) n += exp_q[p].size();
    return n;
  endfunction

  task automatic clear_logs();
    hs_port.delete(); hs_cyc.delete(); hs_first.delete(); rsp_log.delete();
  endtask

  // Load a client command: burst+1 beats for a write, one beat for a read.
  task automatic push_cmd(input int p, input logic rw, input logic [AW-1:0] addr, input int burst,
                          input logic ap, input logic [DW-1:0] wbase, input logic [MW-1:0] mask,
                          input int bad_beat);
    beat_t b;
    int    beats = rw ? 1 : burst + 1;
    for (int i = 0; i < beats; i++) begin
      b.rw     = (i == bad_beat) ? 1'b1 : rw;
      b.exp_rw = rw;
      b.first  = (i == 0);
      b.ap     = ap;
      b.addr   = addr;
      b.wdata  = wbase + DW'(i);
      b.wmask  = mask;
      b.burst  = BW'(burst);
      port_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic drive_ports();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && port_q[p].size() > 0) b = port_q[p].pop_front();
      acc[p] = 1'b0;
      if (port_q[p].size() > 0) begin
        b = port_q[p][0];
        bus.req_valid[p]             = 1'b1;
        bus.req_rw[p]                = b.rw;
        bus.req_ap[p]                = b.ap;
        bus.req_addr[p*AW +: AW]     = b.addr;
        bus.req_wdata[p*DW +: DW]    = b.wdata;
        bus.req_wmask[p*MW +: MW]    = b.wmask;
        bus.req_burst[p*BW +: BW]    = b.burst;
      end else begin
        bus.req_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    beat_t         e;
    int            p;
    logic [NP-1:0] oh;
    for (int i = 0; i < NP; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
    if (bus.cmd_valid && bus.cmd_ready) begin
      p = int'(bus.cmd_port);
      hs_port.push_back(p);
      hs_cyc.push_back(cyc);
      hs_first.push_back(int'(bus.cmd_first));
      check_val("cmd_expected", exp_q[p].size() > 0, 1'b1);
      if (exp_q[p].size() > 0) begin
        e  = exp_q[p].pop_front();
        oh = NP'(1) << p;
        check_val("req_ready", bus.req_ready, oh);
        check_val("cmd_rw", bus.cmd_rw, e.exp_rw);
        check_val("cmd_addr", bus.cmd_addr, e.addr);
        check_val("cmd_wdata", bus.cmd_wdata, e.wdata);
        check_val("cmd_wmask", bus.cmd_wmask, e.wmask);
        check_val("cmd_burst", bus.cmd_burst, e.burst);
        check_val("cmd_ap", bus.cmd_ap, e.ap);
        check_val("cmd_first", bus.cmd_first, e.first);
        if (e.exp_rw) tag_model.push_back(p);
      end
    end
    if (bus.rd_valid) begin
      rsp_log.push_back(bus.rsp_valid);
      if (tag_model.size() == 0) begin
        check_val("rsp_orphan", bus.rsp_valid, '0);
      end else begin
        p  = tag_model[0];
        oh = NP'(1) << p;
        check_val("rsp_valid", bus.rsp_valid, oh);
        check_val("rsp_last", bus.rsp_last, bus.rd_last ? oh : '0);
        check_val("rsp_data", bus.rsp_data[p*DW +: DW], bus.rd_data);
        if (bus.rd_last) p = tag_model.pop_front();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive_ports();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (pending() > 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check_val("drain", pending(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_last = 1'b0;
    bus.rd_data = '0;
    for (int p = 0; p < NP; p++) begin
      port_q[p].delete();
      exp_q[p].delete();
      acc[p] = 1'b0;
    end
    tag_model.delete();
    drive_ports();
    repeat (3) tick();
    check_val("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check_val("rst_req_ready", bus.req_ready, '0);
    check_val("rst_rsp_valid", bus.rsp_valid, '0);
    check_val("rst_rsp_last", bus.rsp_last, '0);
    check_val("rst_err", bus.err, 1'b0);
    check_val("rst_tags_full", bus.tags_full, 1'b0);
    rst_n = 1'b1;
    bus.cmd_ready = 1'b1;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    cyc = 0;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wmask = '0; bus.req_burst = '0; bus.req_ap = '0;
    do_reset();

    // Single write from port 2: one bubble, then issued
    clear_logs();
    push_cmd(2, 1'b0, 24'h000100, 0, 1'b0, 16'hA5A5, 2'b11, -1);
    drive_ports();
    t0 = cyc;
    wait_drain(20);
    check_val("t1_count", hs_port.size(), 1);
    check_val("t1_port", log_port(0), 2);
    check_val("t1_first", log_first(0), 1);
    check_val("t1_latency", log_cyc(0) - t0, 1);
    check_val("t1_idle", bus.cmd_valid, 1'b0);

    // All four ports streaming single writes: round robin, one command per two cycles
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        push_cmd(p, 1'b0, AW'(p * 4096 + r), 0, p[0], DW'(16'h1000 * p + r), MW'(p + 1), -1);
    drive_ports();
    wait_drain(60);
    check_val("t2_count", hs_port.size(), 8);
    for (int i = 0; i < 5; i++) check_val($sformatf("t2_order%0d", i), log_port(i), i % NP);
    for (int i = 1; i < 5; i++) check_val($sformatf("t2_gap%0d", i), log_cyc(i) - log_cyc(i - 1), 2);

    // Port 1 burst of 4 beats locks out port 0 until the last beat
    do_reset();
    push_cmd(0, 1'b0, 24'h000200, 0, 1'b0, 16'h0200, 2'b01, -1);
    drive_ports();
    wait_drain(20);
    clear_logs();
    push_cmd(1, 1'b0, 24'h000300, 3, 1'b1, 16'h3000, 2'b10, -1);
    push_cmd(0, 1'b0, 24'h000400, 0, 1'b0, 16'h4000, 2'b11, -1);
    drive_ports();
    wait_drain(40);
    check_val("t3_count", hs_port.size(), 5);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t3_port%0d", i), log_port(i), 1);
      check_val($sformatf("t3_first%0d", i), log_first(i), (i == 0) ? 1 : 0);
    end
    for (int i = 1; i < 4; i++) check_val($sformatf("t3_gap%0d", i), log_cyc(i) - log_cyc(i - 1), 1);
    check_val("t3_next_port", log_port(4), 0);

    // Burst under toggling cmd_ready: every beat exactly once, in order
    clear_logs();
    bus.cmd_ready = 1'b0;
    push_cmd(3, 1'b0, 24'h000500, 3, 1'b0, 16'h5000, 2'b11, -1);
    drive_ports();
    for (int n = 0; n < 40 && pending() > 0; n++) begin
      bus.cmd_ready = ~bus.cmd_ready;
      tick();
    end
    bus.cmd_ready = 1'b1;
    repeat (3) tick();
    check_val("t4_count", hs_port.size(), 4);
    check_val("t4_first0", log_first(0), 1);
    check_val("t4_first3", log_first(3), 0);
    check_val("t4_left", exp_left(), 0);

    // Tag FIFO fills with 8 reads; writes still pass, reads block until a return
    do_reset();
    clear_logs();
    for (int i = 0; i < TD; i++) push_cmd(3, 1'b1, AW'(24'h000600 + i), 0, 1'b0, '0, 2'b00, -1);
    drive_ports();
    wait_drain(60);
    check_val("t5_reads", hs_port.size(), TD);
    check_val("t5_full", bus.tags_full, 1'b1);
    clear_logs();
    push_cmd(3, 1'b1, 24'h000700, 0, 1'b0, '0, 2'b00, -1);
    push_cmd(0, 1'b0, 24'h000800, 0, 1'b0, 16'h0800, 2'b11, -1);
    drive_ports();
    repeat (10) tick();
    check_val("t5_count", hs_port.size(), 1);
    check_val("t5_write_port", log_port(0), 0);
    check_val("t5_blocked", port_q[3].size(), 1);
    bus.rd_valid = 1'b1; bus.rd_last = 1'b1; bus.rd_data = 16'h1234;
    tick();
    bus.rd_valid = 1'b0; bus.rd_last = 1'b0;
    check_val("t5_full_clr", bus.tags_full, 1'b0);
    clear_logs();
    wait_drain(20);
    check_val("t5_read_port", log_port(0), 3);
    check_val("t5_refull", bus.tags_full, 1'b1);

    // Interleaved read returns route to ports 0 then 2; an orphan beat flags err
    do_reset();
    clear_logs();
    push_cmd(0, 1'b1, 24'h000900, 1, 1'b0, '0, 2'b00, -1);
    push_cmd(2, 1'b1, 24'h000A00, 1, 1'b1, '0, 2'b00, -1);
    drive_ports();
    wait_drain(20);
    check_val("t6_order0", log_port(0), 0);
    check_val("t6_order1", log_port(1), 2);
    for (int i = 0; i < 4; i++) begin
      bus.rd_valid = 1'b1; bus.rd_last = i[0]; bus.rd_data = DW'(16'hB000 + i);
      tick();
    end
    bus.rd_valid = 1'b0; bus.rd_last = 1'b0;
    for (int i = 0; i < 4; i++) check_val($sformatf("t6_beat%0d", i), rsp_at(i), (i < 2) ? 1 : 4);
    check_val("t6_err_clear", bus.err, 1'b0);
    bus.rd_valid = 1'b1; bus.rd_last = 1'b1; bus.rd_data = 16'hDEAD;
    tick();
    bus.rd_valid = 1'b0; bus.rd_last = 1'b0;
    check_val("t6_orphan_rsp", rsp_at(4), 0);
    check_val("t6_err_set", bus.err, 1'b1);

    // Read opcode inside a write burst: forwarded as write, err set
    do_reset();
    clear_logs();
    push_cmd(1, 1'b0, 24'h000B00, 1, 1'b0, 16'hC000, 2'b01, 1);
    drive_ports();
    wait_drain(20);
    check_val("t7_count", hs_port.size(), 2);
    check_val("t7_err", bus.err, 1'b1);

    // Reset mid-burst abandons it; the next command starts cleanly
    bus.cmd_ready = 1'b0;
    push_cmd(2, 1'b0, 24'h000C00, 3, 1'b0, 16'hD000, 2'b11, -1);
    drive_ports();
    repeat (3) tick();
    do_reset();
    clear_logs();
    push_cmd(1, 1'b0, 24'h000D00, 0, 1'b1, 16'hE000, 2'b10, -1);
    drive_ports();
    wait_drain(20);
    check_val("t8_port", log_port(0), 1);
    check_val("t8_first", log_first(0), 1);
    check_val("t8_left", exp_left(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
